bit_reverse_reorder: RTL
========================

// Module: bit_reverse_reorder
// PURPOSE
//  Output-side unscrambler for the in-place FFT. Accepts one frame of N=2^R samples
//  in the core's bit-reversed order and streams them out in natural order.
//  Each input sample at stream index k is written to buffer address bitrev(k).
//  The buffer is then read sequentially.
//  Sits between the FFT core output and downstream consumers. Single buffer:
//  fill phase, then drain phase, with no overlap.
// PARAMETERS
//  R   5    log2 of frame length; N = 2^R samples per frame
//  DW  32   sample width (packed {re,im}), opaque to this block
// PORTS
//  i_clk     in   1   clock, all logic on rising edge
//  i_rstn    in   1   asynchronous active-low reset
//  i_valid   in   1   input sample valid
//  o_ready   out  1   block can accept input (high only in FILL)
//  i_data    in   DW  input sample, bit-reversed frame order
//  o_valid   out  1   output sample valid
//  i_ready   in   1   downstream accepts output
//  o_data    out  DW  output sample, natural order
//  o_last    out  1   high with o_valid on natural index N-1
//  o_busy    out  1   high in DRAIN (frame held, input stalled)
// BEHAVIOUR
//  - Reset (async assert, sync release) drives state=FILL, wr_cnt=0, rd_cnt=0.
//    Outputs after reset: o_ready=1, o_valid=0, o_last=0, o_busy=0, o_data=0.
//    Buffer contents are not reset.
//  - Input handshake: a sample is accepted on a cycle with i_valid & o_ready.
//    On accept: mem[bitrev(wr_cnt)] <= i_data and wr_cnt <= wr_cnt+1 (R bits, wraps).
//  - FILL -> DRAIN: taken on acceptance with wr_cnt==N-1. o_ready drops the next cycle.
//  - DRAIN entry: the same edge loads o_data <= mem[0] (with the just-written sample
//    bypassed if bitrev(N-1)==0, which only occurs for R=0; R>=1 is required).
//    Also on that edge: o_valid<=1, rd_cnt<=1.
//    Latency: first output valid 1 cycle after the last input is accepted.
//  - Output handshake: transfer on o_valid & i_ready.
//    On transfer with rd_cnt!=0: o_data<=mem[rd_cnt] and rd_cnt<=rd_cnt+1.
//    o_last is high when the sample on o_data has natural index N-1.
//    Without i_ready, o_valid/o_data/o_last hold stable (no drop, no duplicate).
//  - DRAIN -> FILL: taken on transfer of the o_last sample. That edge sets o_valid=0,
//    o_last=0, wr_cnt=0, rd_cnt=0, o_ready=1.
//    Gap: the next frame's first sample can be accepted the cycle after the last output.
//  - i_valid during DRAIN is ignored; upstream must hold it under o_ready=0.
//  - Throughput: N input cycles plus N output cycles per frame at full handshake rate.
//  - Reset mid-frame: any partial fill or drain is discarded. The next accepted sample
//    is index 0 of a new frame.
//  - bitrev(k): bit i of k maps to bit R-1-i. Purely combinational on wr_cnt.
// STRUCTURE
//  - Shared package (fft_pkg): localparam N=1<<R; state encoding FILL=1'b0, DRAIN=1'b1.
//  - One sub-module: bitReverse #(.R(R)) maps wr_cnt to the write address.
//    Instantiate the existing mapper; do not re-code it here.
//  - Buffer: N x DW register array (or inferred RAM with a registered output).
//    Single write port, single read port.
// TESTING
//  1 R=3, input 0..7 back-to-back, i_ready=1 -> o_data 0,4,2,6,1,5,3,7.
//    o_last on the 7; first o_valid 1 cycle after the 8th accept.
//  2 R=3, i_ready toggling 1,0,0,1,... -> same sequence.
//    o_data/o_last stable while stalled; exactly 8 transfers.
//  3 Two frames: 0..7 then 8..15 -> 0,4,2,6,1,5,3,7 then 8,12,10,14,9,13,11,15.
//    o_ready=0 throughout the first drain.
//  4 Reset after 5 of 8 inputs, then feed 0..7 -> output 0,4,2,6,1,5,3,7.
//    No stale samples; o_valid=0 during reset.
//  5 Reset asserted mid-drain (after 3 outputs) -> o_valid=0 immediately.
//    o_ready=1 on release; the next frame reorders correctly.
//  6 R=5, DW=32, random data with i_valid gaps -> output index j equals
//    input index bitrev5(j) for all 32 samples (scoreboard).

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output-side blocks.
package fft_pkg;

    // Reorder buffer phase: FILL accepts a frame, DRAIN streams it out.
    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    // Default frame order used by the FFT core (N = 2^R_DEFAULT samples).
    localparam int R_DEFAULT = 5;

endpackage

// File: rtl/bitReverse.sv
// Index mapper: reverses the bit order of an R-bit index.
module bitReverse #(
    parameter int R = 5
) (
    input  logic [R-1:0] idx,
    output logic [R-1:0] rev
);

    // Bit i of the index lands on bit R-1-i of the result.
    always_comb begin
        rev = '0;
        for (int i = 0; i < R; i++) begin
            rev[R-1-i] = idx[i];
        end
    end

endmodule

// File: rtl/bit_reverse_reorder.sv
// Output-side unscrambler for the in-place FFT: writes a bit-reversed frame
// into a single buffer at bitrev(k), then drains it in natural order.
module bit_reverse_reorder
    import fft_pkg::*;
#(
    parameter int R  = 5,
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_data,
    output logic          o_last,
    output logic          o_busy
);

    localparam int N = 32'd1 << R;
    localparam logic [R-1:0] LAST_IDX = R'(N - 1);
    localparam logic [R-1:0] CNT_ONE  = R'(1'b1);

    state_e        state_r;
    state_e        state_next_s;
    logic [R-1:0]  wr_cnt_r;
    logic [R-1:0]  wr_cnt_next_s;
    logic [R-1:0]  rd_cnt_r;
    logic [R-1:0]  rd_cnt_next_s;
    logic [R-1:0]  wr_addr_s;
    logic          valid_next_s;
    logic          last_next_s;
    logic [DW-1:0] data_next_s;
    logic          mem_we_s;
    logic          accept_s;
    logic          xfer_s;
    logic [DW-1:0] mem_r [N];

    // Write address is the bit-reversed input stream index.
    bitReverse #(.R(R)) u_bitrev (
        .idx (wr_cnt_r),
        .rev (wr_addr_s)
    );

    // o_ready is a registered copy of "state is FILL", so it gates acceptance directly.
    always_comb begin
        accept_s = i_valid & o_ready;
        xfer_s   = o_valid & i_ready;
    end

    // Next-state and next-output logic for both phases.
    always_comb begin
        state_next_s  = state_r;
        wr_cnt_next_s = wr_cnt_r;
        rd_cnt_next_s = rd_cnt_r;
        valid_next_s  = o_valid;
        last_next_s   = o_last;
        data_next_s   = o_data;
        mem_we_s      = 1'b0;
        case (state_r)
            FILL: begin
                if (accept_s) begin
                    mem_we_s      = 1'b1;
                    wr_cnt_next_s = wr_cnt_r + CNT_ONE;
                    if (wr_cnt_r == LAST_IDX) begin
                        // bitrev(N-1) != 0 for R >= 1, so mem[0] is already written.
                        state_next_s  = DRAIN;
                        data_next_s   = mem_r[0];
                        valid_next_s  = 1'b1;
                        last_next_s   = 1'b0;
                        rd_cnt_next_s = CNT_ONE;
                    end else begin
                        state_next_s  = FILL;
                    end
                end else begin
                    state_next_s = FILL;
                end
            end
            DRAIN: begin
                if (xfer_s) begin
                    if (o_last) begin
                        // Last natural-order sample leaves: reopen for the next frame.
                        state_next_s  = FILL;
                        valid_next_s  = 1'b0;
                        last_next_s   = 1'b0;
                        wr_cnt_next_s = '0;
                        rd_cnt_next_s = '0;
                    end else begin
                        data_next_s   = mem_r[rd_cnt_r];
                        rd_cnt_next_s = rd_cnt_r + CNT_ONE;
                        last_next_s   = (rd_cnt_r == LAST_IDX);
                    end
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: begin
                state_next_s  = FILL;
                valid_next_s  = 1'b0;
                last_next_s   = 1'b0;
                wr_cnt_next_s = '0;
                rd_cnt_next_s = '0;
            end
        endcase
    end

    // Phase register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_r <= FILL;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Counters and registered outputs; buffer contents are deliberately not reset.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_cnt_r <= '0;
            rd_cnt_r <= '0;
            o_valid  <= 1'b0;
            o_last   <= 1'b0;
            o_data   <= '0;
            o_ready  <= 1'b1;
            o_busy   <= 1'b0;
        end else begin
            wr_cnt_r <= wr_cnt_next_s;
            rd_cnt_r <= rd_cnt_next_s;
            o_valid  <= valid_next_s;
            o_last   <= last_next_s;
            o_data   <= data_next_s;
            o_ready  <= (state_next_s == FILL);
            o_busy   <= (state_next_s == DRAIN);
        end
    end

    // Single-port write into the frame buffer.
    always_ff @(posedge i_clk) begin
        if (mem_we_s) begin
            mem_r[wr_addr_s] <= i_data;
        end
    end

endmodule
